// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational MIPS ALU between two requesters (e.g. an integer
//   EX stage and an address-generation port). A granted request has its
//   operands registered onto the ALU drive for SETTLE_CYCLES cycles. The ALU
//   result and flags are then captured and returned to the winner over a
//   valid/ready response channel.
//
// Parameters
//   SETTLE_CYCLES  cycles the ALU inputs are held before capture (1..15)
//   PRIO_FIXED     0 = round-robin on ties, 1 = port 0 always wins a tie
//
// Optional feature
//   ALU_ARB_OVF_TRAP_EN  adds resp_trap_o. An add/sub/addi that overflows
//                        reports trap=1 and returns a zero result.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   req_valid_i[1:0]/req_ready_o    request handshake, one bit per port
//   req_instr{0,1}_i, req_a*, req_b* instruction/regA/regB per port
//   resp_valid_o[1:0]/resp_ready_i  response handshake, one bit per port
//   resp_result_o, resp_flags_o     captured result, {zero,negative,overflow}
//   resp_trap_o                     overflow trap (only with the macro)
//   alu_instruction_o/regA/regB     registered drive to the shared ALU
//   alu_result_i, alu_flags_i       ALU outputs
//   busy_o                          high whenever not idle
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter bit          PRIO_FIXED    = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [31:0] req_instr0_i,
    input  logic [31:0] req_instr1_i,
    input  logic [31:0] req_a0_i,
    input  logic [31:0] req_a1_i,
    input  logic [31:0] req_b0_i,
    input  logic [31:0] req_b1_i,
    output logic [1:0]  resp_valid_o,
    input  logic [1:0]  resp_ready_i,
    output logic [31:0] resp_result_o,
    output logic [2:0]  resp_flags_o,
`ifdef ALU_ARB_OVF_TRAP_EN
    output logic        resp_trap_o,
`endif
    output logic [31:0] alu_instruction_o,
    output logic [31:0] alu_regA_o,
    output logic [31:0] alu_regB_o,
    input  logic [31:0] alu_result_i,
    input  logic [2:0]  alu_flags_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [31:0] alu_instr_q, alu_instr_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [31:0] res_q, res_d;
    logic [2:0]  flags_q, flags_d;
    logic        trap_q, trap_d;
    logic        gnt;
    logic        ovf_ok;
    logic        ovf_trap_op;
    logic [5:0]  opc, fnc;

    // Tie -> the port that did not win last (or port 0 when fixed priority).
    // With no tie the single valid port wins; with none valid gnt is unused.
    always_comb begin
        if (req_valid_i == 2'b11) gnt = PRIO_FIXED ? 1'b0 : ~last_q;
        else                      gnt = ~req_valid_i[0];
    end

    // The ALU leaves a stale overflow bit on non-arithmetic ops, so it is only
    // forwarded for ops whose overflow is meaningful.
    assign opc = alu_instr_q[31:26];
    assign fnc = alu_instr_q[5:0];

    always_comb begin
        ovf_ok      = 1'b0;
        ovf_trap_op = 1'b0;
        case (opc)
            6'b000000: begin
                ovf_ok      = (fnc == 6'b100000) || (fnc == 6'b100010) || (fnc == 6'b101010);
                ovf_trap_op = (fnc == 6'b100000) || (fnc == 6'b100010);
            end
            6'b001000: begin
                ovf_ok      = 1'b1;
                ovf_trap_op = 1'b1;
            end
            6'b000100, 6'b000101, 6'b100011, 6'b101011, 6'b001010: ovf_ok = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_d       = last_q;
        alu_instr_d  = alu_instr_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        res_d        = res_q;
        flags_d      = flags_q;
        trap_d       = trap_q;
        req_ready_o  = 2'b00;
        resp_valid_o = 2'b00;
        case (state_q)
            IDLE: begin
                // Ready only goes to a valid port, so ready implies handshake.
                if (|req_valid_i && !rst_i) begin
                    req_ready_o[gnt] = 1'b1;
                    owner_d          = gnt;
                    cnt_d            = 4'(SETTLE_CYCLES);
                    alu_instr_d      = gnt ? req_instr1_i : req_instr0_i;
                    alu_a_d          = gnt ? req_a1_i : req_a0_i;
                    alu_b_d          = gnt ? req_b1_i : req_b0_i;
                    state_d          = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    flags_d = {alu_flags_i[2:1], alu_flags_i[0] & ovf_ok};
`ifdef ALU_ARB_OVF_TRAP_EN
                    trap_d  = ovf_trap_op & alu_flags_i[0];
                    res_d   = (ovf_trap_op & alu_flags_i[0]) ? 32'd0 : alu_result_i;
`else
                    trap_d  = 1'b0;
                    res_d   = alu_result_i;
`endif
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid_o[owner_q] = 1'b1;
                if (resp_ready_i[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            alu_instr_q <= 32'd0;
            alu_a_q     <= 32'd0;
            alu_b_q     <= 32'd0;
            res_q       <= 32'd0;
            flags_q     <= 3'd0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            alu_instr_q <= alu_instr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            trap_q      <= trap_d;
        end
    end

    assign alu_instruction_o = alu_instr_q;
    assign alu_regA_o        = alu_a_q;
    assign alu_regB_o        = alu_b_q;
    assign resp_result_o     = res_q;
    assign resp_flags_o      = flags_q;
    assign busy_o            = (state_q != IDLE);
`ifdef ALU_ARB_OVF_TRAP_EN
    assign resp_trap_o       = trap_q;
`else
    // Trap state only exists with the trap feature enabled.
    logic unused_trap;
    assign unused_trap = trap_q ^ ovf_trap_op;
`endif

endmodule
